instruction_fetch: RTL and testbench

Instruction fetch (IF) stage of the 5-stage MIPS pipeline: the producer side of the IF/ID boundary that `instruction_decode` consumes. Holds the PC, a word-addressed instruction memory loadable by the debug unit, and the IF/ID pipeline register. It honours stall and redirect (jump/branch) requests from decode and stops fetching on a HALT instruction.

---
 rtl/instruction_fetch.sv | 167 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Instruction fetch stage of the 5-stage MIPS pipeline. Holds the program
// counter, a word-addressed instruction memory that the debug unit fills
// while the pipeline is not running, and the IF/ID pipeline register that
// instruction_decode consumes. Decode can stall the stage or redirect it to a
// jump/branch target; fetching stops after a HALT instruction has been handed
// to decode.
//
// Parameters
//   NB_DATA      instruction and PC width
//   NB_ADDR      instruction memory word-address width (2^NB_ADDR words)
//   HALT_OPCODE  opcode that halts fetch
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   i_rst          in   synchronous active-high reset (memory is kept)
//   i_start        in   leave IDLE/HALTED and restart fetching at PC 0
//   i_stall        in   hazard stall from decode, freezes PC and IF/ID
//   i_redirect     in   jump or taken branch resolved in decode
//   i_redirect_pc  in   redirect target byte address
//   i_load_en      in   instruction memory write strobe (IDLE/HALTED only)
//   i_load_addr    in   instruction memory write word address
//   i_load_data    in   instruction memory write data
//   o_instruction  out  IF/ID instruction, 0 (NOP) when not valid
//   o_pcounter4    out  IF/ID PC+4 of o_instruction
//   o_pc           out  current fetch PC
//   o_valid        out  IF/ID holds a real instruction
//   o_halt         out  fetch halted
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int         NB_DATA     = 32,
  parameter int         NB_ADDR     = 8,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [NB_DATA-1:0] i_redirect_pc,
  input  logic               i_load_en,
  input  logic [NB_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0] i_load_data,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_valid,
  output logic               o_halt
);

  localparam int MEM_WORDS = 1 << NB_ADDR;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]         state;
  logic [NB_DATA-1:0] pc;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] fetch_word;
  logic [NB_ADDR-1:0] fetch_idx;
  logic               fetch_is_halt;
  logic               load_ok;
  logic [NB_DATA-1:0] instr_q;
  logic [NB_DATA-1:0] pc4_q;
  logic               valid_q;
  logic               halt_q;
  logic               unused_target_bits;

  logic [NB_DATA-1:0] mem [MEM_WORDS];

  // Only the word-index bits of the PC address the memory, so fetch wraps
  // from the last word back to word 0 while the PC keeps counting.
  assign pc_plus4      = pc + NB_DATA'(4);
  assign fetch_idx     = pc[NB_ADDR+1:2];
  assign fetch_word    = mem[fetch_idx];
  assign fetch_is_halt = (fetch_word[NB_DATA-1 -: 6] == HALT_OPCODE);

  // The debug unit may only rewrite the program while nothing is being fetched.
  assign load_ok = i_load_en && !i_rst && (state != ST_RUN);

  // Redirect targets are forced to word alignment, so the low bits are dropped.
  assign unused_target_bits = ^i_redirect_pc[1:0];

  // Instruction memory has no reset so a program survives a pipeline reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pc      <= '0;
          instr_q <= '0;
          pc4_q   <= '0;
          valid_q <= 1'b0;
          halt_q  <= 1'b0;
          if (i_start) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Stall beats redirect: decode re-presents the redirect once the
          // hazard clears, so nothing is lost by ignoring it here.
          if (!i_stall) begin
            if (i_redirect) begin
              // The word fetched this cycle is on the wrong path; it becomes
              // a bubble and fetch resumes at the target next cycle.
              instr_q <= '0;
              pc4_q   <= '0;
              valid_q <= 1'b0;
              pc      <= {i_redirect_pc[NB_DATA-1:2], 2'b00};
            end else begin
              instr_q <= fetch_word;
              pc4_q   <= pc_plus4;
              valid_q <= 1'b1;
              // A HALT is handed to decode once; the PC stays on it so the
              // debug unit can see where the program stopped.
              if (fetch_is_halt) begin
                state <= ST_HALTED;
              end else begin
                pc <= pc_plus4;
              end
            end
          end
        end

        ST_HALTED: begin
          instr_q <= '0;
          pc4_q   <= '0;
          valid_q <= 1'b0;
          if (i_start) begin
            state  <= ST_RUN;
            pc     <= '0;
            halt_q <= 1'b0;
          end else begin
            halt_q <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_instruction = instr_q;
  assign o_pcounter4   = pc4_q;
  assign o_pc          = pc;
  assign o_valid       = valid_q;
  assign o_halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. A behavioural model (memory
// array plus PC / IF/ID values) is advanced once per clock from the same
// inputs driven to the DUT, and every output is compared after each edge.
// Directed steps cover the program-load/halt, stall, redirect and wrap
// scenarios, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;
  localparam int WORDS   = 1 << NB_ADDR;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_HALTED = 2;

  logic               clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic               i_stall;
  logic               i_redirect;
  logic [NB_DATA-1:0] i_redirect_pc;
  logic               i_load_en;
  logic [NB_ADDR-1:0] i_load_addr;
  logic [NB_DATA-1:0] i_load_data;
  logic [NB_DATA-1:0] o_instruction;
  logic [NB_DATA-1:0] o_pcounter4;
  logic [NB_DATA-1:0] o_pc;
  logic               o_valid;
  logic               o_halt;

  int checks = 0;
  int passed = 0;

  // Reference model state.
  logic [31:0] model_mem [WORDS];
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_halt;

  always #5 clk = ~clk;

  instruction_fetch #(
    .NB_DATA     (NB_DATA),
    .NB_ADDR     (NB_ADDR),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_load_en     (i_load_en),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .o_instruction (o_instruction),
    .o_pcounter4   (o_pcounter4),
    .o_pc          (o_pc),
    .o_valid       (o_valid),
    .o_halt        (o_halt)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance the model by one clock edge using the fetch rules directly.
  task automatic modelStep(input logic rst, input logic start, input logic stall,
                           input logic redir, input logic [31:0] rpc, input logic len,
                           input logic [7:0] laddr, input logic [31:0] ldata);
    logic [31:0] word;
    if (rst) begin
      m_mode  = M_IDLE;
      m_pc    = 0;
      m_instr = 0;
      m_pc4   = 0;
      m_valid = 0;
      m_halt  = 0;
    end else if (m_mode == M_IDLE) begin
      m_pc    = 0;
      m_instr = 0;
      m_valid = 0;
      m_halt  = 0;
      if (len) model_mem[laddr] = ldata;
      if (start) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!stall) begin
        if (redir) begin
          m_instr = 0;
          m_valid = 0;
          m_pc    = rpc - (rpc % 4);
        end else begin
          word    = model_mem[(m_pc / 4) % WORDS];
          m_instr = word;
          m_pc4   = m_pc + 4;
          m_valid = 1;
          if (word[31:26] == 6'h3F) m_mode = M_HALTED;
          else m_pc = m_pc + 4;
        end
      end
    end else begin
      m_instr = 0;
      m_valid = 0;
      if (len) model_mem[laddr] = ldata;
      if (start) begin
        m_mode = M_RUN;
        m_pc   = 0;
        m_halt = 0;
      end else begin
        m_halt = 1;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("pc", o_pc, m_pc);
    checkVal("valid", {31'b0, o_valid}, {31'b0, m_valid});
    checkVal("halt", {31'b0, o_halt}, {31'b0, m_halt});
    checkVal("instr", o_instruction, m_instr);
    if (m_valid) checkVal("pc4", o_pcounter4, m_pc4);
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input logic rst, input logic start, input logic stall,
                               input logic redir, input logic [31:0] rpc, input logic len,
                               input logic [7:0] laddr, input logic [31:0] ldata);
    i_rst         = rst;
    i_start       = start;
    i_stall       = stall;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_load_en     = len;
    i_load_addr   = laddr;
    i_load_data   = ldata;
    modelStep(rst, start, stall, redir, rpc, len, laddr, ldata);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic startFetch();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadWord(input logic [7:0] addr, input logic [31:0] data);
    applyStimulus(0, 0, 0, 0, 0, 1, addr, data);
  endtask

  task automatic redirectTo(input logic [31:0] target);
    applyStimulus(0, 0, 0, 1, target, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] w;
    logic        r_rst, r_start, r_stall, r_redir, r_len;
    logic [31:0] r_pc;

    m_mode  = M_IDLE;
    m_pc    = 0;
    m_instr = 0;
    m_pc4   = 0;
    m_valid = 0;
    m_halt  = 0;

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 32'h40, 0, 0, 0);
    checkVal("reset_instr", o_instruction, 32'h0);
    checkVal("reset_pc", o_pc, 32'h0);
    checkVal("reset_halt", {31'b0, o_halt}, 32'h0);

    // Fill memory with random non-HALT words, then the small program.
    for (int i = 0; i < WORDS; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h3F) w[31:26] = 6'h01;
      loadWord(8'(i), w);
    end
    loadWord(8'd0, 32'h00221821);
    loadWord(8'd1, 32'h22220004);
    loadWord(8'd2, 32'hFC000000);

    // Program runs to the HALT and stops with the PC on it.
    startFetch();
    checkVal("start_valid", {31'b0, o_valid}, 32'h0);
    step();
    checkVal("seq0_instr", o_instruction, 32'h00221821);
    checkVal("seq0_pc4", o_pcounter4, 32'd4);
    step();
    checkVal("seq1_instr", o_instruction, 32'h22220004);
    checkVal("seq1_pc4", o_pcounter4, 32'd8);
    step();
    checkVal("seq2_instr", o_instruction, 32'hFC000000);
    checkVal("seq2_pc4", o_pcounter4, 32'd12);
    checkVal("seq2_halt", {31'b0, o_halt}, 32'h0);
    step();
    checkVal("halted_flag", {31'b0, o_halt}, 32'h1);
    checkVal("halted_valid", {31'b0, o_valid}, 32'h0);
    checkVal("halted_pc", o_pc, 32'd8);
    applyStimulus(0, 0, 1, 1, 32'h40, 0, 0, 0);
    checkVal("halted_ignores_redirect", o_pc, 32'd8);

    // Two-cycle stall holding the ADDI in IF/ID.
    startFetch();
    step();
    step();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkVal("stall1_instr", o_instruction, 32'h22220004);
    checkVal("stall1_pc4", o_pcounter4, 32'd8);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkVal("stall2_instr", o_instruction, 32'h22220004);
    checkVal("stall2_pc4", o_pcounter4, 32'd8);
    step();
    checkVal("after_stall_pc4", o_pcounter4, 32'd12);
    step();

    // Jump at word 1, redirect while the HALT at word 2 is being fetched.
    loadWord(8'd1, 32'h08000010);
    startFetch();
    step();
    step();
    checkVal("jump_instr", o_instruction, 32'h08000010);
    redirectTo(32'h40);
    checkVal("bubble_valid", {31'b0, o_valid}, 32'h0);
    checkVal("bubble_instr", o_instruction, 32'h0);
    checkVal("flushed_halt", {31'b0, o_halt}, 32'h0);
    step();
    checkVal("target_instr", o_instruction, model_mem[16]);
    checkVal("target_pc4", o_pcounter4, 32'h44);
    checkVal("target_halt", {31'b0, o_halt}, 32'h0);

    // Misaligned target is word-aligned.
    redirectTo(32'h43);
    step();
    checkVal("misaligned_pc4", o_pcounter4, 32'h44);

    // Stall and redirect together: stall wins; redirect alone is then taken.
    applyStimulus(0, 0, 1, 1, 32'h80, 0, 0, 0);
    checkVal("stall_redirect_pc4", o_pcounter4, 32'h44);
    redirectTo(32'h80);
    step();
    checkVal("redirect_taken_pc4", o_pcounter4, 32'h84);

    // Memory writes during RUN are ignored.
    applyStimulus(0, 0, 0, 0, 0, 1, 8'd16, 32'h0BAD0BAD);
    redirectTo(32'h40);
    step();
    checkVal("run_load_ignored", o_instruction, model_mem[16]);

    // Run on through the wrap to the HALT at word 2.
    for (int i = 0; i < 300; i++) step();
    checkVal("wrap_halted", {31'b0, o_halt}, 32'h1);

    // Replace the HALT and run a full lap of memory.
    loadWord(8'd2, 32'h00000000);
    startFetch();
    for (int i = 0; i < 256; i++) step();
    checkVal("last_word_instr", o_instruction, model_mem[255]);
    checkVal("last_word_pc4", o_pcounter4, 32'h400);
    step();
    checkVal("wrap_instr", o_instruction, model_mem[0]);
    checkVal("wrap_pc4", o_pcounter4, 32'h404);
    step();
    step();

    // Reset mid-run, then confirm the program survived.
    applyStimulus(1, 1, 1, 1, 32'h40, 0, 0, 0);
    checkVal("midrst_instr", o_instruction, 32'h0);
    checkVal("midrst_pc4", o_pcounter4, 32'h0);
    checkVal("midrst_pc", o_pc, 32'h0);
    checkVal("midrst_valid", {31'b0, o_valid}, 32'h0);
    startFetch();
    step();
    checkVal("mem_kept_w0", o_instruction, 32'h00221821);
    step();
    checkVal("mem_kept_w1", o_instruction, 32'h08000010);
    for (int i = 0; i < 4; i++) step();

    // Randomized phase against the model.
    for (int i = 0; i < 800; i++) begin
      r_rst   = ($urandom_range(0, 63) == 0);
      r_start = ($urandom_range(0, 7) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_redir = ($urandom_range(0, 5) == 0);
      r_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      r_len   = !r_rst && ($urandom_range(0, 3) == 0);
      w       = $urandom;
      if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31:26] = 6'h02;
      applyStimulus(r_rst, r_start, r_stall, r_redir, r_pc, r_len, 8'($urandom_range(0, 255)), w);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
